// File: rtl/profile_ctrl.sv
// ============================================================================
// Module   : profile_ctrl
// Brief    : Command sequencer for a bank of up/down profile counters with
//            snapshot capture and registered readout. Optional sticky
//            wrap-around flags when PROFILE_OVERFLOW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module profile_ctrl #(
    parameter int WIDTH       = 32,
    parameter int NR_COUNTERS = 4,
    parameter int SEL_WIDTH   = 2
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic [2:0]             cmdOp,
    input  logic [NR_COUNTERS-1:0] cmdMask,
    input  logic                   cmdDir,
    input  logic [NR_COUNTERS-1:0] events,
    output logic [NR_COUNTERS-1:0] running,
    output logic                   snapValid,
    input  logic [SEL_WIDTH-1:0]   rdSel,
    output logic [WIDTH-1:0]       rdData
`ifdef PROFILE_OVERFLOW_EN
    ,
    output logic [NR_COUNTERS-1:0] ovfl
`endif
);

    localparam logic [2:0]       C_OP_START    = 3'b001;
    localparam logic [2:0]       C_OP_STOP     = 3'b010;
    localparam logic [2:0]       C_OP_CLEAR    = 3'b011;
    localparam logic [2:0]       C_OP_SNAPSHOT = 3'b100;
    localparam logic [2:0]       C_OP_SETDIR   = 3'b101;
    localparam logic [WIDTH-1:0] C_ONE         = WIDTH'(1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_cmd_ready;
    logic [2:0]             r_op;
    logic [NR_COUNTERS-1:0] r_mask;
    logic                   r_dir_cmd;
    logic [NR_COUNTERS-1:0] r_dir;
    logic [NR_COUNTERS-1:0] r_running;
    logic                   r_snap_valid;
    logic [WIDTH-1:0]       r_rd_data;
    logic [WIDTH-1:0]       r_cnt  [NR_COUNTERS];
    logic [WIDTH-1:0]       r_snap [NR_COUNTERS];

    logic [NR_COUNTERS-1:0] w_clr;
    logic [NR_COUNTERS-1:0] w_en;
    logic                   w_snap;
    logic [WIDTH-1:0]       w_rd_mux;

    // INIT clears every counter; a CLEAR command clears only the masked ones.
    always_comb begin
        w_clr = '0;
        if (r_state == S_INIT) begin
            w_clr = '1;
        end else if (r_state == S_EXEC && r_op == C_OP_CLEAR) begin
            w_clr = r_mask;
        end
    end

    assign w_en   = r_running & events;
    assign w_snap = (r_state == S_EXEC) && (r_op == C_OP_SNAPSHOT);

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state      <= S_INIT;
            r_cmd_ready  <= 1'b0;
            r_op         <= 3'b000;
            r_mask       <= '0;
            r_dir_cmd    <= 1'b0;
            r_dir        <= '1;
            r_running    <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                S_IDLE: begin
                    if (cmdValid && r_cmd_ready) begin
                        r_op        <= cmdOp;
                        r_mask      <= cmdMask;
                        r_dir_cmd   <= cmdDir;
                        r_state     <= S_EXEC;
                        r_cmd_ready <= 1'b0;
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        C_OP_START:  r_running <= r_running | r_mask;
                        C_OP_STOP:   r_running <= r_running & ~r_mask;
                        C_OP_SETDIR: r_dir     <= r_dir_cmd ? (r_dir | r_mask) : (r_dir & ~r_mask);
                        default:     ;
                    endcase
                    r_snap_valid <= (r_op == C_OP_SNAPSHOT);
                    r_state      <= S_IDLE;
                    r_cmd_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= S_INIT;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    // Counter datapath has no reset of its own; INIT zeroes it after nReset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NR_COUNTERS; i++) begin
            if (w_clr[i]) begin
                r_cnt[i] <= '0;
            end else if (w_en[i]) begin
                r_cnt[i] <= r_dir[i] ? (r_cnt[i] + C_ONE) : (r_cnt[i] - C_ONE);
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NR_COUNTERS; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_COUNTERS; i++) begin
                if (w_snap && r_mask[i]) begin
                    r_snap[i] <= r_cnt[i];
                end
            end
        end
    end

    // Selects beyond the populated range fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NR_COUNTERS; i++) begin
            if (rdSel == SEL_WIDTH'(i)) begin
                w_rd_mux = r_snap[i];
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

`ifdef PROFILE_OVERFLOW_EN
    logic [NR_COUNTERS-1:0] r_ovfl;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_ovfl <= '0;
        end else begin
            for (int i = 0; i < NR_COUNTERS; i++) begin
                if (w_clr[i]) begin
                    r_ovfl[i] <= 1'b0;
                end else if (w_en[i] && ((r_dir[i] && (r_cnt[i] == '1)) ||
                                         (!r_dir[i] && (r_cnt[i] == '0)))) begin
                    r_ovfl[i] <= 1'b1;
                end
            end
        end
    end

    assign ovfl = r_ovfl;
`endif

    assign cmdReady  = r_cmd_ready;
    assign running   = r_running;
    assign snapValid = r_snap_valid;
    assign rdData    = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_profile_ctrl.sv
// ============================================================================
// Module   : tb_profile_ctrl
// Brief    : Scoreboard bench for profile_ctrl: directed command sequences,
//            queued expectations for readout and snapshot pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_profile_ctrl;

    localparam int WIDTH = 32;
    localparam int NR    = 4;
    localparam int SELW  = 2;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_START = 3'b001;
    localparam logic [2:0] OP_STOP  = 3'b010;
    localparam logic [2:0] OP_CLEAR = 3'b011;
    localparam logic [2:0] OP_SNAP  = 3'b100;
    localparam logic [2:0] OP_SETD  = 3'b101;

    logic             clock = 1'b0;
    logic             nReset = 1'b0;
    logic             cmdValid = 1'b0;
    logic             cmdReady;
    logic [2:0]       cmdOp = 3'b000;
    logic [NR-1:0]    cmdMask = '0;
    logic             cmdDir = 1'b1;
    logic [NR-1:0]    events = '0;
    logic [NR-1:0]    running;
    logic             snapValid;
    logic [SELW-1:0]  rdSel = '0;
    logic [WIDTH-1:0] rdData;
`ifdef PROFILE_OVERFLOW_EN
    logic [NR-1:0]    ovfl;
`endif

    profile_ctrl #(.WIDTH(WIDTH), .NR_COUNTERS(NR), .SEL_WIDTH(SELW)) dut (
        .clock     (clock),
        .nReset    (nReset),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdOp     (cmdOp),
        .cmdMask   (cmdMask),
        .cmdDir    (cmdDir),
        .events    (events),
        .running   (running),
        .snapValid (snapValid),
        .rdSel     (rdSel),
        .rdData    (rdData)
`ifdef PROFILE_OVERFLOW_EN
        ,
        .ovfl      (ovfl)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] val;
    } rd_exp_t;

    rd_exp_t rdq[$];
    string   snapq[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    logic    rd_req   = 1'b0;
    logic    rd_req_q = 1'b0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Readout monitor: compares rdData one cycle after a read request.
    always @(posedge clock) rd_req_q <= rd_req;

    always @(negedge clock) begin
        if (rd_req_q) begin
            if (rdq.size() == 0) begin
                check("rd_unexpected", rdData, '0);
            end else begin
                rd_exp_t e;
                e = rdq.pop_front();
                check(e.tag, rdData, e.val);
            end
        end
    end

    // Snapshot monitor: each pulse must match a pending SNAPSHOT.
    always @(negedge clock) begin
        if (nReset && snapValid) begin
            n_checks++;
            if (snapq.size() == 0) begin
                n_fail++;
                $display("FAIL snapValid_unexpected: got 1, expected 0");
            end else begin
                void'(snapq.pop_front());
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [NR-1:0] mask, input logic dir);
        int t;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdMask  = mask;
        cmdDir   = dir;
        t = 0;
        while (!cmdReady && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!cmdReady) check("cmdReady_timeout", {31'b0, cmdReady}, 1);
        if (op == OP_SNAP) snapq.push_back("snap");
        @(negedge clock);
        cmdValid = 1'b0;
        @(negedge clock);
    endtask

    task automatic rd(input logic [SELW-1:0] sel, input logic [WIDTH-1:0] exp, input string tag);
        rd_exp_t e;
        e.tag = tag;
        e.val = exp;
        rdq.push_back(e);
        rdSel  = sel;
        rd_req = 1'b1;
        @(negedge clock);
        rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and INIT -> IDLE
        repeat (3) @(negedge clock);
        check("rst_cmdReady", {31'b0, cmdReady}, 0);
        check("rst_running", {28'b0, running}, 0);
        check("rst_snapValid", {31'b0, snapValid}, 0);
        check("rst_rdData", rdData, 0);
        nReset = 1'b1;
        check("init_cmdReady", {31'b0, cmdReady}, 0);
        @(negedge clock);
        check("idle_cmdReady", {31'b0, cmdReady}, 1);
        check("idle_running", {28'b0, running}, 0);
        for (int i = 0; i < NR; i++) rd(SELW'(i), 0, "rd_after_reset");

        // Count up counter0 for 10 cycles, counter1 idle
        send(OP_START, 4'b0011, 1'b1);
        check("start_running", {28'b0, running}, 32'h3);
        events = 4'b0001;
        repeat (10) @(negedge clock);
        events = 4'b0000;
        send(OP_STOP, 4'b0011, 1'b1);
        check("stop_running", {28'b0, running}, 0);
        send(OP_SNAP, 4'b1111, 1'b1);
        rd(0, 10, "snap0_up10");
        rd(1, 0, "snap1_idle");

        // Down count from 0 wraps
        send(OP_SETD, 4'b0100, 1'b0);
        send(OP_START, 4'b0100, 1'b1);
        check("start2_running", {28'b0, running}, 32'h4);
        events = 4'b0100;
        repeat (3) @(negedge clock);
        events = 4'b0000;
        send(OP_SNAP, 4'b0100, 1'b1);
        rd(2, 32'hFFFF_FFFD, "snap2_down3");
        rd(0, 10, "snap0_held");
`ifdef PROFILE_OVERFLOW_EN
        check("ovfl2_set", {28'b0, ovfl}, 32'h4);
`endif

        // Clear while running: zero after E1, one on the next edge
        send(OP_START, 4'b0001, 1'b1);
        events = 4'b0001;
        repeat (3) @(negedge clock);
        send(OP_CLEAR, 4'b0001, 1'b1);
        send(OP_SNAP, 4'b0001, 1'b1);
        rd(0, 1, "snap0_after_clear");
        events = 4'b0000;
        send(OP_STOP, 4'b0001, 1'b1);
        check("running_after_stop0", {28'b0, running}, 32'h4);
`ifdef PROFILE_OVERFLOW_EN
        send(OP_CLEAR, 4'b0100, 1'b1);
        check("ovfl2_cleared", {28'b0, ovfl}, 0);
`endif

        // Back-to-back with cmdValid held high
        events   = 4'b0010;
        cmdValid = 1'b1;
        cmdOp = OP_START; cmdMask = 4'b0010; cmdDir = 1'b1;
        check("b2b_ready0", {31'b0, cmdReady}, 1);
        @(negedge clock);
        cmdOp = OP_SNAP; cmdMask = 4'b0010;
        snapq.push_back("snap");
        check("b2b_ready1", {31'b0, cmdReady}, 0);
        @(negedge clock);
        check("b2b_ready2", {31'b0, cmdReady}, 1);
        check("b2b_running_start", {28'b0, running}, 32'h6);
        @(negedge clock);
        cmdOp = OP_STOP; cmdMask = 4'b0010;
        check("b2b_ready3", {31'b0, cmdReady}, 0);
        @(negedge clock);
        check("b2b_ready4", {31'b0, cmdReady}, 1);
        @(negedge clock);
        cmdValid = 1'b0;
        @(negedge clock);
        events = 4'b0000;
        check("b2b_running_stop", {28'b0, running}, 32'h4);
        rd(1, 1, "snap1_b2b");

        // Reset during EXEC discards the command
        cmdValid = 1'b1;
        cmdOp = OP_START; cmdMask = 4'b1111; cmdDir = 1'b1;
        @(negedge clock);
        cmdValid = 1'b0;
        nReset   = 1'b0;
        #1;
        check("mid_rst_running", {28'b0, running}, 0);
        check("mid_rst_cmdReady", {31'b0, cmdReady}, 0);
        check("mid_rst_rdData", rdData, 0);
        @(negedge clock);
        @(negedge clock);
        nReset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", {31'b0, cmdReady}, 1);
        check("post_rst_running", {28'b0, running}, 0);
        send(OP_SNAP, 4'b1111, 1'b1);
        for (int i = 0; i < NR; i++) rd(SELW'(i), 0, "init_cleared");

        // Direction returns to up after reset
        send(OP_START, 4'b0100, 1'b1);
        events = 4'b0100;
        repeat (2) @(negedge clock);
        events = 4'b0000;
        send(OP_SNAP, 4'b0100, 1'b1);
        send(OP_NOP, 4'b0000, 1'b1);
        rd(2, 2, "snap2_dir_reset_up");

        repeat (3) @(negedge clock);
        check("snap_pending", snapq.size(), 0);
        check("rd_pending", rdq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
